activate_seq: RTL and testbench

- Sequencer that time-multiplexes a single shared one-lane activation unit (Q.15 tanh) across an INPUT_SIZE-element vector.
- Accepts a packed vector with a valid/ready handshake and issues one element per cycle to the external activation lane.
- Collects the lane's results into a packed result bus and presents it with a valid/ready handshake.
- Sits between the RNN recurrent-sum stage and the hidden-state register, replacing the fully parallel activation array.

---
 rtl/activate_seq.sv | 118 +++++++++++
 tb/tb_activate_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/activate_seq.sv
// Time-multiplexes one shared activation lane across an INPUT_SIZE-element vector:
// issues one element per cycle, collects the lane's results, and presents them as a packed bus.
module activate_seq #(
    parameter int INPUT_SIZE = 20,
    parameter int BW_IN      = 32,
    parameter int BW_OUT     = 32,
    parameter int ACT_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INPUT_SIZE*BW_IN-1:0]  vector_in_bus,
    output logic                         act_issue,
    output logic [BW_IN-1:0]             act_in,
    input  logic [BW_OUT-1:0]            act_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [INPUT_SIZE*BW_OUT-1:0] result_bus,
    output logic                         busy,
    output logic [1:0]                   dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // valid holds its payload stable until that edge, and ready may be registered.
    localparam int CW = $clog2(INPUT_SIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(INPUT_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state;
    logic [INPUT_SIZE*BW_IN-1:0] vec_q;
    logic [CW-1:0]               issue_idx;
    logic [CW-1:0]               rx_idx;
    logic [ACT_LAT-1:0]          ret_vld;
    logic                        rx_fire;
    logic [CW-1:0]               issue_nxt;

    // The oldest stage of the valid shift register marks the cycle whose act_out belongs to us.
    assign rx_fire   = ret_vld[ACT_LAT-1];
    assign issue_nxt = issue_idx + CW'(1);
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            act_issue  <= 1'b0;
            act_in     <= '0;
            out_valid  <= 1'b0;
            result_bus <= '0;
            vec_q      <= '0;
            issue_idx  <= '0;
            rx_idx     <= '0;
            ret_vld    <= '0;
        end else begin
            ret_vld[0] <= act_issue;
            for (int i = 1; i < ACT_LAT; i++) begin
                ret_vld[i] <= ret_vld[i-1];
            end

            if (rx_fire) begin
                result_bus[rx_idx*BW_OUT +: BW_OUT] <= act_out;
                if (rx_idx != LAST) begin
                    rx_idx <= rx_idx + CW'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        vec_q     <= vector_in_bus;
                        act_issue <= 1'b1;
                        act_in    <= vector_in_bus[BW_IN-1:0];
                        issue_idx <= '0;
                        rx_idx    <= '0;
                        in_ready  <= 1'b0;
                        state     <= ISSUE;
                    end else begin
                        in_ready  <= 1'b1;
                    end
                end
                ISSUE: begin
                    // The issue index parks on the last element rather than wrapping.
                    if (issue_idx == LAST) begin
                        act_issue <= 1'b0;
                        act_in    <= '0;
                        state     <= DRAIN;
                    end else begin
                        issue_idx <= issue_nxt;
                        act_in    <= vec_q[issue_nxt*BW_IN +: BW_IN];
                    end
                end
                DRAIN: begin
                    if (rx_fire && rx_idx == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_activate_seq.sv
// Bench for activate_seq: one instance with a 1-cycle lane and one with a 3-cycle lane,
// each fed by a pipelined lane model that returns act_in + 1.
module tb_activate_seq;

    localparam int N  = 20;
    localparam int W  = 32;
    localparam int VW = N * W;

    logic clk;
    logic rst_n;

    logic          in_valid_a  [2];
    logic          in_ready_a  [2];
    logic [VW-1:0] vec_a       [2];
    logic          act_issue_a [2];
    logic [W-1:0]  act_in_a    [2];
    logic [W-1:0]  act_out_a   [2];
    logic          out_valid_a [2];
    logic          out_ready_a [2];
    logic [VW-1:0] result_a    [2];
    logic          busy_a      [2];
    logic [1:0]    dbg_a       [2];

    logic [W-1:0] exp_q[$];
    int n_checks;
    int n_fail;

    logic [W-1:0] lane1_q;
    logic [W-1:0] lane3_a, lane3_b, lane3_c;

    activate_seq #(.INPUT_SIZE(N), .BW_IN(W), .BW_OUT(W), .ACT_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .vector_in_bus(vec_a[0]),
        .act_issue(act_issue_a[0]), .act_in(act_in_a[0]), .act_out(act_out_a[0]),
        .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]), .result_bus(result_a[0]),
        .busy(busy_a[0]), .dbg_state(dbg_a[0])
    );

    activate_seq #(.INPUT_SIZE(N), .BW_IN(W), .BW_OUT(W), .ACT_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .vector_in_bus(vec_a[1]),
        .act_issue(act_issue_a[1]), .act_in(act_in_a[1]), .act_out(act_out_a[1]),
        .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]), .result_bus(result_a[1]),
        .busy(busy_a[1]), .dbg_state(dbg_a[1])
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Lane models: free-running pipelines, result = input + 1.
    always @(posedge clk) begin
        lane1_q <= act_in_a[0] + 32'd1;
        lane3_a <= act_in_a[1] + 32'd1;
        lane3_b <= lane3_a;
        lane3_c <= lane3_b;
    end
    assign act_out_a[0] = lane1_q;
    assign act_out_a[1] = lane3_c;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic scramble_input(input int d);
        for (int k = 0; k < N; k++) vec_a[d][k*W +: W] = $urandom();
    endtask

    // Drives one vector through instance d and checks it cycle by cycle against the timing rules:
    // issue in cycles 1..N, out_valid from cycle N+lat+1, slot k = element k + 1.
    task automatic run_vec(input int d, input logic [VW-1:0] vec, input bit perturb, input int hold);
        int lat;
        int done_c;
        int waitc;
        logic [VW-1:0] exp_vec;
        logic [W-1:0] e;
        lat    = (d == 0) ? 1 : 3;
        done_c = N + lat + 1;
        for (int k = 0; k < N; k++) exp_q.push_back(vec[k*W +: W] + 32'd1);

        in_valid_a[d] = 1'b1;
        vec_a[d]      = vec;
        waitc = 0;
        while (in_ready_a[d] !== 1'b1 && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        chk($sformatf("d%0d_accept_wait", d), waitc < 50, 1'b1);
        @(negedge clk);
        in_valid_a[d] = 1'b0;
        scramble_input(d);

        for (int c = 1; c <= done_c; c++) begin
            chk($sformatf("d%0d_issue_c%0d", d, c), act_issue_a[d], c <= N);
            chk($sformatf("d%0d_act_in_c%0d", d, c), act_in_a[d], (c <= N) ? vec[(c-1)*W +: W] : '0);
            chk($sformatf("d%0d_out_valid_c%0d", d, c), out_valid_a[d], c == done_c);
            chk($sformatf("d%0d_busy_c%0d", d, c), busy_a[d], 1'b1);
            chk($sformatf("d%0d_in_ready_c%0d", d, c), in_ready_a[d], 1'b0);
            if (perturb && c == 2) begin
                vec_a[d]      = {N{32'h00007FFF}};
                in_valid_a[d] = 1'b1;
            end
            if (perturb && c == 3) in_valid_a[d] = 1'b0;
            if (c < done_c) @(negedge clk);
        end

        exp_vec = '0;
        for (int k = 0; k < N; k++) begin
            e = exp_q.pop_front();
            exp_vec[k*W +: W] = e;
            chk($sformatf("d%0d_slot%0d", d, k), result_a[d][k*W +: W], e);
        end

        for (int h = 0; h < hold; h++) begin
            in_valid_a[d] = 1'b1;
            scramble_input(d);
            @(negedge clk);
            chk($sformatf("d%0d_hold_valid_h%0d", d, h), out_valid_a[d], 1'b1);
            chk($sformatf("d%0d_hold_ready_h%0d", d, h), in_ready_a[d], 1'b0);
            chk($sformatf("d%0d_hold_bus_h%0d", d, h), result_a[d], exp_vec);
        end

        in_valid_a[d]  = 1'b0;
        out_ready_a[d] = 1'b1;
        @(negedge clk);
        out_ready_a[d] = 1'b0;
        chk($sformatf("d%0d_post_out_valid", d), out_valid_a[d], 1'b0);
        chk($sformatf("d%0d_post_in_ready", d), in_ready_a[d], 1'b1);
        chk($sformatf("d%0d_post_busy", d), busy_a[d], 1'b0);
        chk($sformatf("d%0d_post_bus", d), result_a[d], exp_vec);
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_d%0d_in_ready", tag, d), in_ready_a[d], 1'b0);
            chk($sformatf("%s_d%0d_issue", tag, d), act_issue_a[d], 1'b0);
            chk($sformatf("%s_d%0d_act_in", tag, d), act_in_a[d], '0);
            chk($sformatf("%s_d%0d_out_valid", tag, d), out_valid_a[d], 1'b0);
            chk($sformatf("%s_d%0d_bus", tag, d), result_a[d], '0);
            chk($sformatf("%s_d%0d_busy", tag, d), busy_a[d], 1'b0);
            chk($sformatf("%s_d%0d_state", tag, d), dbg_a[d], 2'd0);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    logic [VW-1:0] plan_vec;
    logic [VW-1:0] rnd_vec;
    logic [VW-1:0] hundred_vec;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid_a[d]  = 1'b0;
            out_ready_a[d] = 1'b0;
            vec_a[d]       = '0;
        end
        plan_vec = '0;
        plan_vec[19*W +: W] = 32'sd69632;
        plan_vec[18*W +: W] = -32'sd51200;
        plan_vec[17*W +: W] = -32'sd18432;
        hundred_vec = {N{32'd100}};

        // Reset held for 3 cycles, outputs checked while held.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rel_d%0d_in_ready", d), in_ready_a[d], 1'b1);
            chk($sformatf("rel_d%0d_busy", d), busy_a[d], 1'b0);
            chk($sformatf("rel_d%0d_bus", d), result_a[d], '0);
        end

        // Basic vector, backpressure, input change after acceptance.
        run_vec(0, plan_vec, 1'b0, 0);
        run_vec(0, plan_vec, 1'b0, 10);
        run_vec(0, plan_vec, 1'b1, 0);

        // Three-cycle lane.
        run_vec(1, plan_vec, 1'b0, 0);
        run_vec(1, plan_vec, 1'b1, 4);

        // Random vectors on both instances.
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) rnd_vec[k*W +: W] = $urandom();
            run_vec(r % 2, rnd_vec, 1'b0, $urandom_range(0, 3));
        end

        // Reset in cycle 10 of a transfer.
        in_valid_a[0] = 1'b1;
        vec_a[0]      = plan_vec;
        @(negedge clk);
        in_valid_a[0] = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_issue_before_reset", act_issue_a[0], 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_issue", act_issue_a[0], 1'b0);
        chk("mid_rst_busy", busy_a[0], 1'b0);
        chk("mid_rst_act_in", act_in_a[0], '0);
        chk("mid_rst_out_valid", out_valid_a[0], 1'b0);
        chk("mid_rst_in_ready", in_ready_a[0], 1'b0);
        chk("mid_rst_bus", result_a[0], '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_in_ready", in_ready_a[0], 1'b1);
        chk("mid_rel_bus", result_a[0], '0);
        chk("mid_rel_out_valid", out_valid_a[0], 1'b0);
        run_vec(0, hundred_vec, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
